vga_draw_ctrl: RTL and testbench

Write-side controller for the VGA frame buffer. It arbitrates one frame-buffer write port between two requesters: direct CPU pixel writes and an internal rectangle-fill engine. Both produce the packed pixel word {colour[11:0], y[9:0], x[9:0]} with a single write strobe. It sits between the CPU bus decode and the frame-buffer memory, and is configured through a small register window.

---
 rtl/vga_draw_ctrl_pkg.sv | 39 +++
 rtl/vga_draw_ctrl_arb.sv | 55 +++++
 rtl/vga_draw_ctrl.sv | 168 ++++++++++++++++
 tb/tb_vga_draw_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_draw_ctrl_pkg.sv
// Shared definitions for the VGA frame-buffer write controller.
package vga_draw_ctrl_pkg;

    // Register window indices
    localparam logic [2:0] REG_XY0    = 3'd0;
    localparam logic [2:0] REG_XY1    = 3'd1;
    localparam logic [2:0] REG_COLOUR = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    // CTRL bit positions (write-only pulses)
    localparam int unsigned CTRL_START      = 0;
    localparam int unsigned CTRL_WAIT_FRAME = 1;
    localparam int unsigned CTRL_ABORT      = 2;

    // Packed pixel word field offsets
    localparam int unsigned X_LSB = 0;
    localparam int unsigned Y_LSB = 10;
    localparam int unsigned C_LSB = 20;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_FILL       = 2'd2,
        ST_DONE       = 2'd3
    } fill_state_t;

    function automatic logic [31:0] pack_px(input logic [11:0] colour,
                                            input logic [9:0]  y,
                                            input logic [9:0]  x);
        logic [31:0] px;
        px = '0;
        px[C_LSB +: 12] = colour;
        px[Y_LSB +: 10] = y;
        px[X_LSB +: 10] = x;
        return px;
    endfunction

endpackage

// File: rtl/vga_draw_ctrl_arb.sv
// Two-requester round-robin arbiter (CPU vs fill engine) with registered write port.
module vga_wr_arb
    import vga_draw_ctrl_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH  = 800,
    parameter int unsigned DISPLAY_HEIGHT = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_data,
    input  logic        fill_req,
    input  logic [31:0] fill_data,
    output logic        cpu_grant,
    output logic        fill_grant,
    output logic [31:0] vga_wdata,
    output logic        vga_we
);

    localparam logic [9:0] X_LIM = 10'(DISPLAY_WIDTH);
    localparam logic [9:0] Y_LIM = 10'(DISPLAY_HEIGHT);

    logic rr;
    logic contested;
    logic cpu_in_range;

    // Grant decode: uncontested requester wins, contested case follows rr
    always_comb begin
        contested    = cpu_valid && fill_req;
        cpu_grant    = cpu_valid && (!fill_req || !rr);
        fill_grant   = fill_req && (!cpu_valid || rr);
        cpu_in_range = (cpu_data[X_LSB +: 10] < X_LIM) && (cpu_data[Y_LSB +: 10] < Y_LIM);
    end

    // Round-robin pointer and registered frame-buffer write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr        <= 1'b0;
            vga_we    <= 1'b0;
            vga_wdata <= '0;
        end else begin
            if (contested) begin
                rr <= ~rr;
            end
            // Out-of-range CPU pixels are accepted upstream but never written
            vga_we <= (cpu_grant && cpu_in_range) || fill_grant;
            if (cpu_grant && cpu_in_range) begin
                vga_wdata <= cpu_data;
            end else if (fill_grant) begin
                vga_wdata <= fill_data;
            end
        end
    end

endmodule

// File: rtl/vga_draw_ctrl.sv
// VGA frame-buffer write controller: config registers, rectangle-fill FSM, arbiter instance.
module vga_draw_ctrl
    import vga_draw_ctrl_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH  = 800,
    parameter int unsigned DISPLAY_HEIGHT = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_px_valid,
    input  logic [31:0] cpu_px_data,
    output logic        cpu_px_ready,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    input  logic        frame_trig,
    output logic [31:0] vga_wdata,
    output logic        vga_we,
    output logic        busy,
    output logic        done_pulse
);

    localparam logic [9:0] X_MAX = 10'(DISPLAY_WIDTH - 1);
    localparam logic [9:0] Y_MAX = 10'(DISPLAY_HEIGHT - 1);

    fill_state_t state, state_next;

    logic [9:0]  x0_r, y0_r, x1_r, y1_r;
    logic [11:0] colour_r;
    logic [9:0]  lx0, lx1, ly1;
    logic [11:0] lcol;
    logic [9:0]  cx, cy;
    logic [9:0]  x1_clip, y1_clip;
    logic        fill_empty;
    logic        start_cmd, wait_cmd, abort_cmd;
    logic        last_px;
    logic        cpu_grant, fill_grant;
    logic [31:0] fill_data;

    // Command decode, clipping and fill-engine datapath
    always_comb begin
        start_cmd  = cfg_we && (cfg_addr == REG_CTRL) && cfg_wdata[CTRL_START];
        wait_cmd   = cfg_wdata[CTRL_WAIT_FRAME];
        abort_cmd  = cfg_we && (cfg_addr == REG_CTRL) && cfg_wdata[CTRL_ABORT];
        x1_clip    = (x1_r > X_MAX) ? X_MAX : x1_r;
        y1_clip    = (y1_r > Y_MAX) ? Y_MAX : y1_r;
        fill_empty = (x0_r > X_MAX) || (y0_r > Y_MAX) || (x0_r > x1_clip) || (y0_r > y1_clip);
        last_px    = (cx == lx1) && (cy == ly1);
        fill_data  = pack_px(lcol, cy, cx);
    end

    // Configuration registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x0_r     <= '0;
            y0_r     <= '0;
            x1_r     <= '0;
            y1_r     <= '0;
            colour_r <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                REG_XY0: begin
                    x0_r <= cfg_wdata[X_LSB +: 10];
                    y0_r <= cfg_wdata[Y_LSB +: 10];
                end
                REG_XY1: begin
                    x1_r <= cfg_wdata[X_LSB +: 10];
                    y1_r <= cfg_wdata[Y_LSB +: 10];
                end
                REG_COLOUR: colour_r <= cfg_wdata[11:0];
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_cmd) begin
                    if (fill_empty)    state_next = ST_DONE;
                    else if (wait_cmd) state_next = ST_WAIT_FRAME;
                    else               state_next = ST_FILL;
                end
            end
            ST_WAIT_FRAME: begin
                if (abort_cmd)       state_next = ST_IDLE;
                else if (frame_trig) state_next = ST_FILL;
            end
            ST_FILL: begin
                if (abort_cmd)                   state_next = ST_IDLE;
                else if (fill_grant && last_px)  state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Latched fill parameters and row-major pixel counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lx0  <= '0;
            lx1  <= '0;
            ly1  <= '0;
            lcol <= '0;
            cx   <= '0;
            cy   <= '0;
        end else if (state == ST_IDLE && start_cmd) begin
            lx0  <= x0_r;
            lx1  <= x1_clip;
            ly1  <= y1_clip;
            lcol <= colour_r;
            cx   <= x0_r;
            cy   <= y0_r;
        end else if (state == ST_FILL && fill_grant) begin
            if (cx == lx1) begin
                cx <= lx0;
                cy <= cy + 10'd1;
            end else begin
                cx <= cx + 10'd1;
            end
        end
    end

    // Register readback and status outputs
    always_comb begin
        busy       = (state != ST_IDLE);
        done_pulse = (state == ST_DONE);
        cfg_rdata  = '0;
        case (cfg_addr)
            REG_XY0:    cfg_rdata = {12'd0, y0_r, x0_r};
            REG_XY1:    cfg_rdata = {12'd0, y1_r, x1_r};
            REG_COLOUR: cfg_rdata = {20'd0, colour_r};
            REG_STATUS: cfg_rdata = {29'd0, busy, state};
            default:    cfg_rdata = '0;
        endcase
    end

    vga_wr_arb #(
        .DISPLAY_WIDTH  (DISPLAY_WIDTH),
        .DISPLAY_HEIGHT (DISPLAY_HEIGHT)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .cpu_valid  (cpu_px_valid),
        .cpu_data   (cpu_px_data),
        .fill_req   (state == ST_FILL),
        .fill_data  (fill_data),
        .cpu_grant  (cpu_grant),
        .fill_grant (fill_grant),
        .vga_wdata  (vga_wdata),
        .vga_we     (vga_we)
    );

    assign cpu_px_ready = cpu_grant;

endmodule

// File: tb/tb_vga_draw_ctrl.sv
// Scoreboard bench for vga_draw_ctrl: queued expected writes checked by a negedge monitor.
module tb_vga_draw_ctrl;
    import vga_draw_ctrl_pkg::*;

    localparam int W = 800;
    localparam int H = 600;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_px_valid = 1'b0;
    logic [31:0] cpu_px_data = '0;
    logic        cpu_px_ready;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = REG_STATUS;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        frame_trig = 1'b0;
    logic [31:0] vga_wdata;
    logic        vga_we;
    logic        busy;
    logic        done_pulse;

    int total = 0;
    int bad = 0;
    int cpu_wr = 0;
    int fill_wr = 0;
    int done_cnt = 0;
    logic [31:0] cpu_q[$];
    logic [31:0] fill_q[$];
    bit stop_cpu = 0;

    vga_draw_ctrl #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H)) dut (
        .clk(clk), .rst(rst),
        .cpu_px_valid(cpu_px_valid), .cpu_px_data(cpu_px_data), .cpu_px_ready(cpu_px_ready),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .frame_trig(frame_trig), .vga_wdata(vga_wdata), .vga_we(vga_we),
        .busy(busy), .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    // Monitor: every frame-buffer write must be the head of one of the expected queues
    always @(negedge clk) begin
        if (rst) begin
            if (vga_we) begin
                total++;
                if (cpu_q.size() > 0 && cpu_q[0] == vga_wdata) begin
                    void'(cpu_q.pop_front());
                    cpu_wr++;
                end else if (fill_q.size() > 0 && fill_q[0] == vga_wdata) begin
                    void'(fill_q.pop_front());
                    fill_wr++;
                end else begin
                    bad++;
                    $display("FAIL write: got %h, want cpu head %h or fill head %h",
                             vga_wdata, (cpu_q.size() > 0) ? cpu_q[0] : 32'h0,
                             (fill_q.size() > 0) ? fill_q[0] : 32'h0);
                end
            end
            if (done_pulse) done_cnt++;
            if (cpu_px_valid && cpu_px_ready &&
                int'(cpu_px_data[9:0]) < W && int'(cpu_px_data[19:10]) < H)
                cpu_q.push_back(cpu_px_data);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        cfg_addr = REG_STATUS;
        cfg_wdata = '0;
    endtask

    // Reference: clip to the screen, then enumerate the rectangle row by row
    task automatic model_fill(input int x0, input int y0, input int x1, input int y1,
                              input logic [11:0] col);
        int xe, ye;
        xe = (x1 > W - 1) ? W - 1 : x1;
        ye = (y1 > H - 1) ? H - 1 : y1;
        if (x0 >= W || y0 >= H) return;
        for (int y = y0; y <= ye; y++)
            for (int x = x0; x <= xe; x++)
                fill_q.push_back({col, 10'(y), 10'(x)});
    endtask

    task automatic start_fill(input bit wait_f, input int x0, input int y0,
                              input int x1, input int y1, input logic [11:0] col);
        cfg_write(REG_XY0, {12'd0, 10'(y0), 10'(x0)});
        cfg_write(REG_XY1, {12'd0, 10'(y1), 10'(x1)});
        cfg_write(REG_COLOUR, {20'd0, col});
        model_fill(x0 & 1023, y0 & 1023, x1 & 1023, y1 & 1023, col);
        cfg_write(REG_CTRL, {29'd0, 1'b0, wait_f, 1'b1});
    endtask

    // Counts negedges from now until done_pulse; returns re-aligned to posedge+1
    task automatic wait_done(input int limit, output int cycles, output bit ok);
        ok = 0;
        cycles = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_pulse) begin
                cycles = i;
                ok = 1;
                break;
            end
        end
        tick();
    endtask

    function automatic logic [31:0] rand_px();
        return {12'($urandom), 10'($urandom_range(0, 650)), 10'($urandom_range(0, 850))};
    endfunction

    initial begin
        int cyc, base, base2, dbase, n, fillc, cpu_in_fill;
        bit ok, acc, first;

        // Reset state
        #3;
        check("rst_we", {31'd0, vga_we}, 32'd0);
        check("rst_wdata", vga_wdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done_pulse}, 32'd0);
        check("rst_status", cfg_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // 1: single CPU pixel
        base = cpu_wr;
        cpu_px_valid = 1'b1;
        cpu_px_data = {12'hABC, 10'd50, 10'd100};
        #1;
        check("t1_ready", {31'd0, cpu_px_ready}, 32'd1);
        tick();
        cpu_px_valid = 1'b0;
        check("t1_we", {31'd0, vga_we}, 32'd1);
        check("t1_wdata", vga_wdata, 32'hABC0C864);
        repeat (3) tick();
        check("t1_count", cpu_wr - base, 1);

        // 2: uncontested 3x2 fill
        base = fill_wr;
        start_fill(0, 2, 3, 4, 4, 12'hF00);
        wait_done(40, cyc, ok);
        check("t2_done", {31'd0, ok}, 32'd1);
        check("t2_cycles", cyc, 6);
        check("t2_pulse_width", {31'd0, done_pulse}, 32'd0);
        check("t2_busy_after", {31'd0, busy}, 32'd0);
        check("t2_writes", fill_wr - base, 6);
        cfg_addr = REG_XY1;
        #1 check("t2_xy1_rd", cfg_rdata, {12'd0, 10'd4, 10'd4});
        cfg_addr = 3'd6;
        #1 check("t2_unmapped_rd", cfg_rdata, 32'd0);
        cfg_addr = REG_STATUS;

        // 3: same fill with CPU continuously requesting
        base = fill_wr;
        start_fill(0, 2, 3, 4, 4, 12'hF00);
        cpu_px_valid = 1'b1;
        cpu_px_data = {12'h123, 10'd7, 10'd9};
        fillc = 0;
        cpu_in_fill = 0;
        first = 0;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            acc = cpu_px_ready;
            if (i == 0) first = acc;
            if (cfg_rdata[1:0] == 2'd2) begin
                fillc++;
                if (acc) cpu_in_fill++;
            end
            if (done_pulse) begin
                ok = 1;
                break;
            end
            tick();
            if (acc) cpu_px_data = {12'($urandom), 10'($urandom_range(0, 599)), 10'($urandom_range(0, 799))};
        end
        tick();
        cpu_px_valid = 1'b0;
        repeat (3) tick();
        check("t3_done", {31'd0, ok}, 32'd1);
        check("t3_cpu_first", {31'd0, first}, 32'd1);
        check("t3_fill_cycles", fillc, 12);
        check("t3_cpu_in_fill", cpu_in_fill, 6);
        check("t3_fill_writes", fill_wr - base, 6);

        // 4: wait for frame trigger
        base = fill_wr;
        start_fill(1, 10, 20, 11, 20, 12'h0A5);
        repeat (5) tick();
        check("t4_no_writes", fill_wr - base, 0);
        check("t4_status", cfg_rdata, 32'h5);
        frame_trig = 1'b1;
        tick();
        frame_trig = 1'b0;
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (vga_we) begin
                n = i;
                break;
            end
        end
        tick();
        check("t4_latency", n, 2);
        wait_done(20, cyc, ok);
        check("t4_done", {31'd0, ok}, 32'd1);
        check("t4_writes", fill_wr - base, 2);

        // 5: clipping and empty rectangle
        base = fill_wr;
        start_fill(0, 798, 598, 900, 700, 12'h777);
        wait_done(40, cyc, ok);
        check("t5_clip_done", {31'd0, ok}, 32'd1);
        check("t5_clip_writes", fill_wr - base, 4);
        base = fill_wr;
        start_fill(0, 5, 5, 4, 9, 12'h777);
        wait_done(10, cyc, ok);
        check("t5_empty_latency", cyc, 0);
        check("t5_empty_writes", fill_wr - base, 0);

        // 6: abort after three pixels
        base = fill_wr;
        dbase = done_cnt;
        start_fill(0, 0, 0, 9, 9, 12'h3C3);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fill_wr - base >= 3) break;
        end
        tick();
        cfg_write(REG_CTRL, 32'h4);
        base2 = fill_wr;
        repeat (5) tick();
        check("t6_extra_le1", {31'd0, (fill_wr - base2) <= 1}, 32'd1);
        check("t6_no_done", done_cnt - dbase, 0);
        check("t6_idle", cfg_rdata, 32'd0);
        fill_q.delete();

        // 6b: asynchronous reset mid-fill
        start_fill(0, 0, 0, 9, 9, 12'h3C3);
        repeat (3) tick();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_we", {31'd0, vga_we}, 32'd0);
        check("t6_rst_status", cfg_rdata, 32'd0);
        cfg_addr = REG_XY0;
        #1 check("t6_rst_xy0", cfg_rdata, 32'd0);
        cfg_addr = REG_STATUS;
        tick();
        rst = 1'b1;
        fill_q.delete();
        cpu_q.delete();
        tick();

        // Random: fills under random CPU traffic, including off-screen CPU pixels
        fork
            begin
                while (!stop_cpu) begin
                    @(negedge clk);
                    acc = cpu_px_valid && cpu_px_ready;
                    tick();
                    if (!cpu_px_valid || acc) begin
                        cpu_px_valid = 1'($urandom_range(0, 1));
                        cpu_px_data = rand_px();
                    end
                end
                cpu_px_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    int rx0, ry0, rx1, ry1;
                    rx0 = $urandom_range(0, 810);
                    ry0 = $urandom_range(0, 610);
                    rx1 = (k == 3) ? rx0 - 1 : rx0 + $urandom_range(0, 3);
                    ry1 = ry0 + $urandom_range(0, 3);
                    if (rx1 < 0) rx1 = 0;
                    start_fill(0, rx0, ry0, rx1, ry1, 12'($urandom));
                    wait_done(100, cyc, ok);
                    check("rnd_done", {31'd0, ok}, 32'd1);
                    repeat (2) tick();
                end
                stop_cpu = 1;
            end
        join

        repeat (6) tick();
        check("end_cpu_q_empty", cpu_q.size(), 0);
        check("end_fill_q_empty", fill_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
